// File: rtl/four_bit_add_sub_pkg.sv
// Shared constants for the registered ripple-carry adder/subtractor.
// Latency: n/a (constants only).
// Backpressure: n/a.
package four_bit_add_sub_pkg;

    // Default operand/result width
    localparam int ADD_SUB_WIDTH = 4;

    // Mode encoding on ctrl
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/four_bit_add_sub_if.sv
// Operand/result bundle for four_bit_add_sub; ovf member exists only with FOUR_BIT_ADD_SUB_OVF_EN.
// Latency: n/a (wiring only).
// Backpressure: none, results are presented unconditionally one cycle after in_valid.
interface four_bit_add_sub_if
    import four_bit_add_sub_pkg::*;
#(
    parameter int WIDTH = ADD_SUB_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ctrl;
    logic [WIDTH-1:0] sd;
    logic             cb;
    logic             out_valid;
`ifdef FOUR_BIT_ADD_SUB_OVF_EN
    logic             ovf;

    modport master (output in_valid, a, b, ctrl, input sd, cb, out_valid, ovf);
    modport slave  (input in_valid, a, b, ctrl, output sd, cb, out_valid, ovf);
`else
    modport master (output in_valid, a, b, ctrl, input sd, cb, out_valid);
    modport slave  (input in_valid, a, b, ctrl, output sd, cb, out_valid);
`endif

endinterface

// File: rtl/four_bit_add_sub_full_adder.sv
// One-bit full adder, the cell of the ripple chain.
// Latency: combinational.
// Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/four_bit_add_sub.sv
// Registered ripple-carry A+B / A-B (A + ~B + 1); optional signed overflow via FOUR_BIT_ADD_SUB_OVF_EN.
// Latency: 1 cycle from in_valid to out_valid; one result per cycle when in_valid is held high.
// Backpressure: none; outputs hold when in_valid is low, out_valid pulses for one cycle per result.
module four_bit_add_sub
    import four_bit_add_sub_pkg::*;
#(
    parameter int WIDTH = ADD_SUB_WIDTH
)(
    input  logic             clk,
    input  logic             rst,
    four_bit_add_sub_if.slave bus
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("four_bit_add_sub: WIDTH must be in 2..32");
    end

    // Subtraction reuses the adder: invert B and inject ctrl as the carry-in
    logic             sub_mode;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;

    assign sub_mode = (bus.ctrl == OP_SUB);
    assign b_eff    = bus.b ^ {WIDTH{sub_mode}};

    // Per-stage carry scalars keep each link of the chain a distinct net
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic cin;
        logic cout;

        if (i == 0) begin : g_lsb
            assign cin = sub_mode;
        end else begin : g_mid
            assign cin = g_bit[i-1].cout;
        end

        full_adder u_fa (
            .a    (bus.a[i]),
            .b    (b_eff[i]),
            .cin  (cin),
            .s    (sum[i]),
            .cout (cout)
        );
    end

    logic             carry_out;
    logic [WIDTH-1:0] sd_q;
    logic             cb_q;
    logic             vld_q;

    assign carry_out = g_bit[WIDTH-1].cout;

    // Capture result on in_valid; out_valid tracks in_valid one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sd_q  <= '0;
            cb_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                sd_q <= sum;
                cb_q <= carry_out;
            end
        end
    end

    assign bus.sd        = sd_q;
    assign bus.cb        = cb_q;
    assign bus.out_valid = vld_q;

`ifdef FOUR_BIT_ADD_SUB_OVF_EN
    logic ovf_q;
    logic ovf_n;

    // Signed overflow: carry into the MSB disagrees with carry out of it
    assign ovf_n = g_bit[WIDTH-1].cin ^ carry_out;

    // Overflow flag registered alongside the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (bus.in_valid) begin
            ovf_q <= ovf_n;
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_four_bit_add_sub.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops on out_valid.
module tb_four_bit_add_sub;
    import four_bit_add_sub_pkg::*;

    localparam int W = ADD_SUB_WIDTH;

    typedef struct packed {
        logic [W-1:0] sd;
        logic         cb;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    four_bit_add_sub_if #(.WIDTH(W)) bus_if ();

    four_bit_add_sub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    // Illegal X on ctrl while sampling
    always @(posedge clk) begin
        if (!rst && bus_if.in_valid) begin
            assert (!$isunknown(bus_if.ctrl))
            else $error("FAIL ctrl_x: ctrl unknown while in_valid high");
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ctrl,
                        input logic [W-1:0] sd, input logic cb, input logic ovf);
        exp_t e;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b1;
        bus_if.a        = a;
        bus_if.b        = b;
        bus_if.ctrl     = ctrl;
        e.sd  = sd;
        e.cb  = cb;
        e.ovf = ovf;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    // Monitor: every out_valid must match the oldest outstanding expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bus_if.out_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got sd=%0h cb=%0b, expected no output", bus_if.sd, bus_if.cb);
            end else begin
                e = sb_q.pop_front();
                check("sd", 32'(bus_if.sd), 32'(e.sd));
                check("cb", 32'(bus_if.cb), 32'(e.cb));
`ifdef FOUR_BIT_ADD_SUB_OVF_EN
                check("ovf", 32'(bus_if.ovf), 32'(e.ovf));
`endif
            end
        end
    end

    initial begin
        bus_if.in_valid = 1'b0;
        bus_if.a        = '0;
        bus_if.b        = '0;
        bus_if.ctrl     = OP_ADD;

        // Reset state
        #3;
        check("rst_sd", 32'(bus_if.sd), 32'd0);
        check("rst_cb", 32'(bus_if.cb), 32'd0);
        check("rst_vld", 32'(bus_if.out_valid), 32'd0);
`ifdef FOUR_BIT_ADD_SUB_OVF_EN
        check("rst_ovf", 32'(bus_if.ovf), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors (hand-computed)
        send(4'b1101, 4'b1010, OP_ADD, 4'b0111, 1'b1, 1'b1);
        send(4'b1101, 4'b1010, OP_SUB, 4'b0011, 1'b1, 1'b0);
        send(4'b0011, 4'b0101, OP_SUB, 4'b1110, 1'b0, 1'b0);
        send(4'b0111, 4'b0001, OP_ADD, 4'b1000, 1'b0, 1'b1);
        send(4'b1000, 4'b0001, OP_SUB, 4'b0111, 1'b1, 1'b1);
        idle();

        // Hold: outputs stay at the last result while in_valid is low
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #2;
            check("hold_vld", 32'(bus_if.out_valid), 32'd0);
            check("hold_sd", 32'(bus_if.sd), 32'b0111);
            check("hold_cb", 32'(bus_if.cb), 32'd1);
`ifdef FOUR_BIT_ADD_SUB_OVF_EN
            check("hold_ovf", 32'(bus_if.ovf), 32'd1);
`endif
        end

        // Back-to-back results in order
        send(4'b0001, 4'b0010, OP_ADD, 4'b0011, 1'b0, 1'b0);
        send(4'b1111, 4'b0001, OP_ADD, 4'b0000, 1'b1, 1'b0);
        send(4'b0000, 4'b0001, OP_SUB, 4'b1111, 1'b0, 1'b0);
        send(4'b0101, 4'b0101, OP_SUB, 4'b0000, 1'b1, 1'b0);

        // Async reset between edges while a result is being presented
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("arst_sd", 32'(bus_if.sd), 32'd0);
        check("arst_cb", 32'(bus_if.cb), 32'd0);
        check("arst_vld", 32'(bus_if.out_valid), 32'd0);
`ifdef FOUR_BIT_ADD_SUB_OVF_EN
        check("arst_ovf", 32'(bus_if.ovf), 32'd0);
`endif
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Results resume after release
        send(4'b0110, 4'b0011, OP_ADD, 4'b1001, 1'b0, 1'b1);
        send(4'b0010, 4'b0111, OP_SUB, 4'b1011, 1'b0, 1'b0);

        // Exhaustive sweep against the reference sum
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    logic [W-1:0] av;
                    logic [W-1:0] bv;
                    logic [W-1:0] beff;
                    logic         cv;
                    int           s;
                    logic [W:0]   r;
                    av   = i[W-1:0];
                    bv   = j[W-1:0];
                    cv   = (c != 0);
                    beff = bv ^ {W{cv}};
                    s    = int'(av) + int'(beff) + int'(cv);
                    r    = s[W:0];
                    send(av, bv, cv, r[W-1:0], r[W],
                         (av[W-1] == beff[W-1]) && (r[W-1] != av[W-1]));
                end
            end
        end
        idle();
        idle();
        idle();

        check("drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
